pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register that supersedes the fixed per-stage latch registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload of WIDTH bits between two stages with a valid/ready handshake, an optional two-entry skid buffer, synchronous flush with optional payload zeroing, and a saturating stall-cycle counter for performance analysis. Each stage boundary instantiates one copy; the stage packs its control and data fields into the payload vector.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_stage_reg_if.sv | 36 +++
 rtl/sat_counter.sv | 29 ++
 rtl/pipe_stage_reg.sv | 131 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the elastic pipeline register
//
// Contents:
//   pipe_state_t   occupancy state of a skid-buffered stage (EMPTY, ONE, FULL)
//   occ_count()    entry count from the main/skid valid flags
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    function automatic logic [1:0] occ_count(input logic m_valid, input logic s_valid);
        return {1'b0, m_valid} + {1'b0, s_valid};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - handshake, control and status bundle of one pipeline stage boundary
//
// Signals:
//   in_valid/in_ready/in_data     upstream payload handshake
//   out_valid/out_ready/out_data  downstream payload handshake
//   flush                         synchronous squash of stored and incoming payload
//   occupancy                     number of stored entries (0..2)
//   stall_cnt/stall_clr           saturating stall-cycle counter and its clear
// Modports:
//   master  the environment around the stage (drives inputs, observes outputs)
//   slave   the pipeline register itself
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_clr;

    modport master (
        output in_valid, in_data, out_ready, flush, stall_clr,
        input  in_ready, out_valid, out_data, occupancy, stall_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush, stall_clr,
        output in_ready, out_valid, out_data, occupancy, stall_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
//
// Ports:
//   CLK    clock, rising edge
//   nRST   asynchronous active-low reset, clears count
//   inc    count one event this cycle
//   clr    clear count; wins over inc
//   count  current value, holds at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline register with optional skid entry, flush and stall counter
//
// Parameters:
//   WIDTH          payload width
//   SKID           1: main + skid entry, in_ready from registers; 0: single entry, combinational in_ready
//   ZERO_ON_FLUSH  1: flush also zeroes stored payload; 0: only valid flags are cleared
//   CNT_W          stall counter width
// Ports:
//   CLK    clock, rising edge
//   nRST   asynchronous active-low reset
//   bus    pipe_stage_reg_if slave: handshakes, flush, occupancy, stall counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SKID          = 1,
    parameter int ZERO_ON_FLUSH = 1,
    parameter int CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    pipe_stage_reg_if.slave  bus
);

    logic             accept;
    logic             drain;
    logic             m_valid;
    logic             s_valid;
    logic             in_ready_w;
    logic [WIDTH-1:0] m_data;
    logic [CNT_W-1:0] stall_q;

    assign accept = bus.in_valid & in_ready_w;
    assign drain  = m_valid & bus.out_ready;

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_t      state;
            logic [WIDTH-1:0] s_data;

            // The skid entry only fills when M is held, so M is always the oldest entry.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    state  <= EMPTY;
                    m_data <= '0;
                    s_data <= '0;
                end else if (bus.flush) begin
                    state <= EMPTY;
                    if (ZERO_ON_FLUSH != 0) begin
                        m_data <= '0;
                        s_data <= '0;
                    end
                end else begin
                    case (state)
                        EMPTY: begin
                            if (accept) begin
                                m_data <= bus.in_data;
                                state  <= ONE;
                            end
                        end
                        ONE: begin
                            if (accept && drain) begin
                                m_data <= bus.in_data;
                            end else if (drain) begin
                                state <= EMPTY;
                            end else if (accept) begin
                                s_data <= bus.in_data;
                                state  <= FULL;
                            end
                        end
                        FULL: begin
                            if (drain) begin
                                m_data <= s_data;
                                state  <= ONE;
                            end
                        end
                        default: begin
                            state <= EMPTY;
                        end
                    endcase
                end
            end

            assign m_valid    = (state != EMPTY);
            assign s_valid    = (state == FULL);
            // Ready comes straight from the state register: no path from out_ready.
            assign in_ready_w = (state != FULL);
        end else begin : g_single
            logic m_valid_q;

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    m_valid_q <= 1'b0;
                    m_data    <= '0;
                end else if (bus.flush) begin
                    m_valid_q <= 1'b0;
                    if (ZERO_ON_FLUSH != 0) begin
                        m_data <= '0;
                    end
                end else if (accept) begin
                    m_valid_q <= 1'b1;
                    m_data    <= bus.in_data;
                end else if (drain) begin
                    m_valid_q <= 1'b0;
                end
            end

            assign m_valid    = m_valid_q;
            assign s_valid    = 1'b0;
            // Accept while the held entry leaves this same cycle, so streaming has no bubble.
            assign in_ready_w = ~m_valid_q | bus.out_ready;
        end
    endgenerate

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (m_valid & ~bus.out_ready),
        .clr   (bus.stall_clr),
        .count (stall_q)
    );

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = m_valid;
    assign bus.out_data  = m_data;
    assign bus.occupancy = occ_count(m_valid, s_valid);
    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (skid, single-entry and narrow-counter builds)
module tb_pipe_stage_reg;

    logic CLK;
    logic nRST;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    pipe_stage_reg_if #(.WIDTH(32), .CNT_W(16)) a ();
    pipe_stage_reg_if #(.WIDTH(32), .CNT_W(16)) b ();
    pipe_stage_reg_if #(.WIDTH(32), .CNT_W(2))  c ();

    pipe_stage_reg #(.WIDTH(32), .SKID(1), .ZERO_ON_FLUSH(1), .CNT_W(16)) dut_skid (
        .CLK (CLK), .nRST (nRST), .bus (a)
    );
    pipe_stage_reg #(.WIDTH(32), .SKID(0), .ZERO_ON_FLUSH(1), .CNT_W(16)) dut_single (
        .CLK (CLK), .nRST (nRST), .bus (b)
    );
    pipe_stage_reg #(.WIDTH(32), .SKID(1), .ZERO_ON_FLUSH(1), .CNT_W(2)) dut_cnt2 (
        .CLK (CLK), .nRST (nRST), .bus (c)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] qc[$];

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic        cd;
        logic [31:0] ed;
        logic [1:0]  eocc;
        logic        eir;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b1; a.flush = 1'b0; a.stall_clr = 1'b0;
        b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b1; b.flush = 1'b0; b.stall_clr = 1'b0;
        c.in_valid = 1'b0; c.in_data = '0; c.out_ready = 1'b1; c.flush = 1'b0; c.stall_clr = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven. Scores the transfers of the
    // coming rising edge, then checks occupancy against the scoreboard depth.
    task automatic step();
        logic [31:0] exp;
        #1;
        if (a.out_valid && a.out_ready) begin
            if (qa.size() == 0) begin
                chk("a_spurious_out", a.out_data, 32'hxxxx_xxxx);
            end else begin
                exp = qa.pop_front();
                chk("a_out_data", a.out_data, exp);
            end
        end
        if (a.flush) qa.delete();
        else if (a.in_valid && a.in_ready) qa.push_back(a.in_data);

        if (b.out_valid && b.out_ready) begin
            if (qb.size() == 0) begin
                chk("b_spurious_out", b.out_data, 32'hxxxx_xxxx);
            end else begin
                exp = qb.pop_front();
                chk("b_out_data", b.out_data, exp);
            end
        end
        if (b.flush) qb.delete();
        else if (b.in_valid && b.in_ready) qb.push_back(b.in_data);

        if (c.out_valid && c.out_ready) begin
            if (qc.size() == 0) begin
                chk("c_spurious_out", c.out_data, 32'hxxxx_xxxx);
            end else begin
                exp = qc.pop_front();
                chk("c_out_data", c.out_data, exp);
            end
        end
        if (c.flush) qc.delete();
        else if (c.in_valid && c.in_ready) qc.push_back(c.in_data);

        @(posedge CLK);
        @(negedge CLK);
        chk("a_occupancy", {30'd0, a.occupancy}, qa.size());
        chk("b_occupancy", {30'd0, b.occupancy}, qb.size());
        chk("c_occupancy", {30'd0, c.occupancy}, qc.size());
    endtask

    initial begin
        //            iv  data          ordy fl   ev  cd  exp data      occ   ir
        tbl[0]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 2'd1, 1'b1};
        tbl[1]  = '{1'b1, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000001, 2'd1, 1'b1};
        tbl[2]  = '{1'b1, 32'h00000002, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, 2'd2, 1'b0};
        tbl[3]  = '{1'b1, 32'h00000003, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, 2'd2, 1'b0};
        tbl[4]  = '{1'b1, 32'h00000003, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000002, 2'd1, 1'b1};
        tbl[5]  = '{1'b1, 32'h00000003, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000003, 2'd1, 1'b1};
        tbl[6]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 2'd0, 1'b1};
        tbl[7]  = '{1'b1, 32'h00000010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000010, 2'd1, 1'b1};
        tbl[8]  = '{1'b1, 32'h00000011, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000010, 2'd2, 1'b0};
        tbl[9]  = '{1'b1, 32'h000000AA, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 2'd0, 1'b1};
        tbl[10] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000000, 2'd0, 1'b1};
        tbl[11] = '{1'b1, 32'h00000055, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000055, 2'd1, 1'b1};
        tbl[12] = '{1'b1, 32'h000000BB, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 2'd0, 1'b1};
        tbl[13] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000000, 2'd0, 1'b1};

        nRST = 1'b0;
        idle_all();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // Reset state
        chk("rst_a_out_valid", {31'd0, a.out_valid}, 32'd0);
        chk("rst_a_out_data",  a.out_data, 32'd0);
        chk("rst_a_occupancy", {30'd0, a.occupancy}, 32'd0);
        chk("rst_a_stall_cnt", {16'd0, a.stall_cnt}, 32'd0);
        chk("rst_a_in_ready",  {31'd0, a.in_ready}, 32'd1);
        chk("rst_b_in_ready",  {31'd0, b.in_ready}, 32'd1);
        chk("rst_b_out_valid", {31'd0, b.out_valid}, 32'd0);

        // Table: skid build through stream, backpressure, release and flush
        for (int i = 0; i < 14; i++) begin
            a.in_valid  = tbl[i].iv;
            a.in_data   = tbl[i].d;
            a.out_ready = tbl[i].ordy;
            a.flush     = tbl[i].fl;
            step();
            chk($sformatf("tbl%0d_out_valid", i), {31'd0, a.out_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].cd) chk($sformatf("tbl%0d_out_data", i), a.out_data, tbl[i].ed);
            chk($sformatf("tbl%0d_occupancy", i), {30'd0, a.occupancy}, {30'd0, tbl[i].eocc});
            chk($sformatf("tbl%0d_in_ready", i), {31'd0, a.in_ready}, {31'd0, tbl[i].eir});
        end
        idle_all();

        // Stall counter: clear, 5 stall cycles, clear wins over increment
        a.stall_clr = 1'b1; a.in_valid = 1'b1; a.in_data = 32'h77; a.out_ready = 1'b0;
        step();
        chk("stall_after_clr", {16'd0, a.stall_cnt}, 32'd0);
        a.stall_clr = 1'b0; a.in_valid = 1'b0;
        repeat (5) step();
        chk("stall_5", {16'd0, a.stall_cnt}, 32'd5);
        a.stall_clr = 1'b1;
        step();
        chk("stall_clr_priority", {16'd0, a.stall_cnt}, 32'd0);
        a.stall_clr = 1'b0; a.out_ready = 1'b1;
        step();
        chk("stall_after_drain", {16'd0, a.stall_cnt}, 32'd0);

        // Narrow counter saturates at 3
        c.in_valid = 1'b1; c.in_data = 32'h5; c.out_ready = 1'b0;
        step();
        chk("c_stall_0", {30'd0, c.stall_cnt}, 32'd0);
        c.in_valid = 1'b0;
        repeat (3) step();
        chk("c_stall_3", {30'd0, c.stall_cnt}, 32'd3);
        repeat (3) step();
        chk("c_stall_sat", {30'd0, c.stall_cnt}, 32'd3);
        c.out_ready = 1'b1;
        step();
        chk("c_stall_hold", {30'd0, c.stall_cnt}, 32'd3);

        // Single-entry build: continuous streaming, then same-cycle backpressure
        b.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b.in_valid = 1'b1; b.in_data = 32'h100 + i;
            #1;
            chk("b_stream_in_ready", {31'd0, b.in_ready}, 32'd1);
            step();
            chk("b_stream_out_valid", {31'd0, b.out_valid}, 32'd1);
            chk("b_stream_out_data", b.out_data, 32'h100 + i);
        end
        b.in_data = 32'h200; b.out_ready = 1'b0;
        #1;
        chk("b_backpressure_in_ready", {31'd0, b.in_ready}, 32'd0);
        step();
        chk("b_hold_data", b.out_data, 32'h107);
        b.out_ready = 1'b1;
        step();
        chk("b_after_release", b.out_data, 32'h200);
        b.in_valid = 1'b0;
        step();
        chk("b_drained", {31'd0, b.out_valid}, 32'd0);

        // Asynchronous reset with two entries held
        a.in_valid = 1'b1; a.in_data = 32'hC1; a.out_ready = 1'b0;
        step();
        a.in_data = 32'hC2;
        step();
        chk("pre_rst_occupancy", {30'd0, a.occupancy}, 32'd2);
        #2;
        nRST = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, a.out_valid}, 32'd0);
        chk("async_rst_out_data",  a.out_data, 32'd0);
        chk("async_rst_occupancy", {30'd0, a.occupancy}, 32'd0);
        chk("async_rst_in_ready",  {31'd0, a.in_ready}, 32'd1);
        chk("async_rst_stall_cnt", {16'd0, a.stall_cnt}, 32'd0);
        qa.delete(); qb.delete(); qc.delete();
        idle_all();
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        a.in_valid = 1'b1; a.in_data = 32'hE1; a.out_ready = 1'b1;
        step();
        chk("post_rst_first", a.out_data, 32'hE1);
        a.in_data = 32'hE2;
        step();
        chk("post_rst_second", a.out_data, 32'hE2);
        a.in_valid = 1'b0;
        step();
        chk("post_rst_empty", {31'd0, a.out_valid}, 32'd0);
        chk("scoreboard_a_empty", qa.size(), 32'd0);
        chk("scoreboard_b_empty", qb.size(), 32'd0);
        chk("scoreboard_c_empty", qc.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
